// File: rtl/imem_refill_responder_if.sv
// rtl/imem_refill_responder_if.sv - refill request/response channel between fetch cache and responder
interface imem_refill_responder_if #(
    parameter int LINE_WORDS = 4
);
    localparam int OW = $clog2(LINE_WORDS);

    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic [OW-1:0] resp_word_idx;
    logic          resp_last;

    // Cache side: issues refill requests and consumes beats.
    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_word_idx, resp_last
    );

    // Responder side: accepts requests and produces beats.
    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_word_idx, resp_last
    );
endinterface

// File: rtl/imem_refill_responder.sv
// rtl/imem_refill_responder.sv - instruction line refill responder with critical-word-first burst
module imem_refill_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    imem_refill_responder_if.slave  bus,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [31:0]             wr_addr,
    input  logic [31:0]             wr_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int BW = AW - OW;
    // Wide enough to hold LATENCY itself, and at least one bit when LATENCY is 0.
    localparam int LW = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          armed_q;
    logic [LW-1:0] lat_q;
    logic [BW-1:0] base_q;
    logic [OW-1:0] idx_q;
    logic [OW-1:0] beat_q;
    logic          last_beat;

    logic [31:0]   mem [MEM_WORDS];

    // Address bits outside the store and the byte offset carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0],
                                wr_addr[31:AW+2], wr_addr[1:0]};

    assign last_beat = (beat_q == OW'(LINE_WORDS - 1));

    // Program-load write port; the store is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW+1:2]] <= wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and channel outputs; beats are read straight from the registered line position.
    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_last      = 1'b0;
        bus.resp_data      = '0;
        bus.resp_word_idx  = idx_q;
        busy               = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // armed_q holds req_ready low for the first cycle out of reset.
                bus.req_ready = armed_q;
                if (bus.req_valid && armed_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The access window spans LATENCY+1 cycles, so the first beat lands
                // LATENCY+1 edges after acceptance (one edge when LATENCY is 0).
                if (lat_q == '0) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                bus.resp_valid = 1'b1;
                bus.resp_last  = last_beat;
                bus.resp_data  = mem[{base_q, idx_q}];
                if (bus.resp_ready && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, latency countdown and beat position; idx_q wraps inside the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            lat_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && armed_q) begin
                        base_q <= bus.req_addr[AW+1:OW+2];
                        idx_q  <= bus.req_addr[OW+1:2];
                        beat_q <= '0;
                        lat_q  <= LW'(LATENCY);
                    end
                end
                WAIT: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                BURST: begin
                    if (bus.resp_ready) begin
                        idx_q  <= idx_q + OW'(1);
                        beat_q <= beat_q + OW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_refill_responder.sv
// tb/tb_imem_refill_responder.sv - scoreboard bench for imem_refill_responder
module tb_imem_refill_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        busy_z;

    always #5 clk = ~clk;

    imem_refill_responder_if #(.LINE_WORDS(4)) bus ();
    imem_refill_responder_if #(.LINE_WORDS(4)) bus_z ();

    imem_refill_responder #(.MEM_WORDS(1024), .LINE_WORDS(4), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_refill_responder #(.MEM_WORDS(1024), .LINE_WORDS(4), .LATENCY(0)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z), .busy(busy_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        last;
        int          word;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] model_mem [1024];
    int          n_checks;
    int          n_fail;
    int          hs_cnt = 0;
    int          hs_cnt_z = 0;

    always @(posedge clk) begin
        if (bus.resp_valid && bus.resp_ready) hs_cnt <= hs_cnt + 1;
        if (bus_z.resp_valid && bus_z.resp_ready) hs_cnt_z <= hs_cnt_z + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_line(input logic [31:0] addr);
        int w, base, crit;
        beat_t e;
        w    = int'(addr[11:2]);
        base = w & ~3;
        crit = w & 3;
        for (int k = 0; k < 4; k++) begin
            e.idx  = 2'((crit + k) % 4);
            e.word = base + int'(e.idx);
            e.data = model_mem[e.word];
            e.last = (k == 3);
            exp_q.push_back(e);
        end
    endfunction

    task automatic load_word(input int w, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 32'(w) << 2; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[w] = d;
    endtask

    task automatic run_request(input string name, input logic [31:0] addr, input int stall_beat,
                               input int stall_n, input bit wr_mid, input int wr_word,
                               input logic [31:0] wr_val);
        int n, edges, beat, stall, guard, hs0;
        beat_t e;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready);
        end
        push_line(addr);
        hs0 = hs_cnt;
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = addr;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_addr = 32'hDEAD_BEEF;
        n_checks++;
        if (bus.req_ready !== 1'b0 || busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b busy=%b resp_valid=%b want 0 1 0",
                     name, bus.req_ready, busy, bus.resp_valid);
        end
        edges = 0;
        while (bus.resp_valid !== 1'b1 && edges < 40) begin
            if (wr_mid && edges == 0) begin
                wr_en = 1'b1; wr_addr = 32'(wr_word) << 2; wr_data = wr_val;
                model_mem[wr_word] = wr_val;
                foreach (exp_q[i]) if (exp_q[i].word == wr_word) exp_q[i].data = wr_val;
            end
            @(negedge clk);
            wr_en = 1'b0;
            edges++;
        end
        n_checks++;
        if (edges !== LAT + 1) begin
            n_fail++; $display("FAIL %s latency: got %0d edges want %0d", name, edges, LAT + 1);
        end
        beat = 0; stall = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            guard++;
            e = exp_q[0];
            n_checks++;
            if (bus.resp_valid !== 1'b1) begin
                n_fail++; $display("FAIL %s resp_valid beat %0d: got %b want 1", name, beat, bus.resp_valid);
            end else begin
                n_checks++;
                if ({bus.resp_word_idx, bus.resp_data, bus.resp_last} !== {e.idx, e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL %s beat %0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             name, beat, bus.resp_word_idx, bus.resp_data, bus.resp_last,
                             e.idx, e.data, e.last);
                end
                if (beat == stall_beat && stall < stall_n) begin
                    bus.resp_ready = 1'b0; stall++;
                end else begin
                    bus.resp_ready = 1'b1; void'(exp_q.pop_front()); beat++;
                end
            end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s burst timeout: %0d beats left want 0", name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: resp_valid=%b req_ready=%b busy=%b want 0 1 0",
                     name, bus.resp_valid, bus.req_ready, busy);
        end
        n_checks++;
        if (hs_cnt - hs0 !== 4) begin
            n_fail++; $display("FAIL %s handshakes: got %0d want 4", name, hs_cnt - hs0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_last, busy, bus.resp_data, bus.resp_word_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b vld=%b last=%b busy=%b data=%h idx=%0d want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_last, busy, bus.resp_data, bus.resp_word_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus_z.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release req_ready: got %b/%b want 1/1", bus.req_ready, bus_z.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.req_valid = 1'b1; bus.req_addr = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.resp_valid, busy, bus.req_ready, bus.resp_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_in_wait: vld=%b busy=%b rdy=%b last=%b want 0 0 0 0",
                     bus.resp_valid, busy, bus.req_ready, bus.resp_last);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_word_idx !== 2'd2 || bus.resp_data !== model_mem[32'h42]) begin
            n_fail++;
            $display("FAIL rst_burst_beat2: vld=%b idx=%0d data=%h want 1 2 %h",
                     bus.resp_valid, bus.resp_word_idx, bus.resp_data, model_mem[32'h42]);
        end
        rst = 1'b1; bus.resp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.resp_valid, busy, bus.req_ready, bus.resp_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_in_burst: vld=%b busy=%b rdy=%b last=%b want 0 0 0 0",
                     bus.resp_valid, busy, bus.req_ready, bus.resp_last);
        end
        rst = 1'b0; bus.resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_discard: vld=%b rdy=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
        run_request("after_rst", 32'h100, -1, 0, 1'b0, 0, 32'h0);
    endtask

    task automatic test_latency_zero();
        int n, hs0;
        beat_t e;
        n = 0;
        while (bus_z.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        push_line(32'h0);
        hs0 = hs_cnt_z;
        bus_z.resp_ready = 1'b1;
        bus_z.req_valid = 1'b1; bus_z.req_addr = 32'h0;
        @(negedge clk);
        n_checks++;
        if (bus_z.resp_valid !== 1'b0 || busy_z !== 1'b1) begin
            n_fail++; $display("FAIL lat0_accept: vld=%b busy=%b want 0 1", bus_z.resp_valid, busy_z);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({bus_z.resp_valid, bus_z.req_ready, bus_z.resp_word_idx, bus_z.resp_data, bus_z.resp_last}
                !== {1'b1, 1'b0, e.idx, e.data, e.last}) begin
                n_fail++;
                $display("FAIL lat0_beat%0d: vld=%b rdy=%b idx=%0d data=%h last=%b want 1 0 %0d %h %b",
                         k, bus_z.resp_valid, bus_z.req_ready, bus_z.resp_word_idx, bus_z.resp_data,
                         bus_z.resp_last, e.idx, e.data, e.last);
            end
            @(negedge clk);
        end
        bus_z.req_valid = 1'b0;
        n_checks++;
        if (hs_cnt_z - hs0 !== 4 || busy_z !== 1'b0 || bus_z.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_end: handshakes=%0d busy=%b vld=%b want 4 0 0",
                     hs_cnt_z - hs0, busy_z, bus_z.resp_valid);
        end
    endtask

    task automatic test_critical_first();
        run_request("line_aligned", 32'h100, -1, 0, 1'b0, 0, 32'h0);
        run_request("crit_word2", 32'h10A, -1, 0, 1'b0, 0, 32'h0);
    endtask

    task automatic test_backpressure();
        run_request("stall_beat1", 32'h100, 1, 5, 1'b0, 0, 32'h0);
    endtask

    task automatic test_addr_wrap();
        run_request("top_wrap", 32'h0000_1FFC, -1, 0, 1'b0, 0, 32'h0);
    endtask

    task automatic test_write_in_wait();
        run_request("write_in_wait", 32'h100, -1, 0, 1'b1, 32'h43, 32'h0000_BEEF);
    endtask

    task automatic test_back_to_back();
        run_request("b2b_first", 32'h104, 2, 1, 1'b0, 0, 32'h0);
        run_request("b2b_second", 32'h8, -1, 0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b1;
        bus_z.req_valid = 1'b0; bus_z.req_addr = '0; bus_z.resp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) model_mem[i] = 'x;
        @(negedge clk);
        test_reset();
        for (int i = 0; i < 4; i++) begin
            load_word(32'h40 + i, 32'hA0 + 32'(i));
            load_word(i, 32'h1000 + 32'(i));
            load_word(32'h3FC + i, 32'hF0 + 32'(i));
        end
        test_critical_first();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid();
        test_latency_zero();
        test_write_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
